pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Program-counter stage of the MIPS core. It sits directly downstream of the branch-offset shifter. It consumes the already-shifted branch offset and the shifted jump field, and holds the architectural PC register. It sequences instruction fetches over a req/ack handshake with instruction memory, honours pipeline stalls, and selects among sequential, branch and jump targets.

Parameters:
WIDTH, 32, PC / address width in bits (must be >= 28)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  input  1  core clock; all state updates on rising edge
RST  input  1  reset; asynchronous assert, active-low; synchronous release assumed from reset synchroniser
Stall  input  1  hazard stall from pipeline control; freezes PC update
Branch_Taken  input  1  branch resolved taken for current instruction
Jump  input  1  current instruction is J/JAL
Branch_Offset  input  WIDTH  sign-extended immediate already shifted left by two; two's complement
Jump_Field  input  28  instr[25:0] already shifted left by two
Imem_Ack  input  1  instruction memory accepted request and returned data this cycle
Imem_Req  output  1  fetch request at address PC
PC  output  WIDTH  current fetch address
PC_Plus4  output  WIDTH  PC + 4 (modulo 2^WIDTH), combinational from PC
Fetch_Valid  output  1  one-cycle pulse: instruction at PC delivered

Behaviour:
- Reset (RST=0, any time, including mid-fetch or in HOLD):
  - state=BOOT, PC=RESET_VECTOR, Imem_Req=0, Fetch_Valid=0.
  - An outstanding request is abandoned; no ack is tracked.
- States:
  - BOOT: Imem_Req=0. Unconditionally goes to FETCH on the next edge after reset release; exactly one idle cycle.
  - FETCH: Imem_Req=1.
    - Imem_Ack=0: stay in FETCH, PC held.
    - Imem_Ack=1, Stall=0: Fetch_Valid=1 next cycle, PC<=next_pc, stay in FETCH (back-to-back fetch, throughput 1/cycle).
    - Imem_Ack=1, Stall=1: Fetch_Valid=1 next cycle, PC held, go to HOLD.
  - HOLD: Imem_Req=0. Imem_Ack ignored.
    - Stall=1: stay in HOLD.
    - Stall=0: PC<=next_pc, go to FETCH.
- Fetch_Valid is registered, high for exactly one cycle per accepted ack, and 0 in all other cycles.
- next_pc is evaluated from inputs in the cycle the PC updates. Priority is Jump > Branch_Taken > sequential:
  - jump: {PC_Plus4[WIDTH-1:28], Jump_Field}
  - branch: PC_Plus4 + Branch_Offset, truncated to WIDTH
  - sequential: PC_Plus4
- Arithmetic is modulo 2^WIDTH. PC=32'hFFFF_FFFC sequential wraps to 0. Negative offsets wrap correctly.
- Imem_Ack in BOOT or HOLD is ignored (no PC change, no Fetch_Valid).
- Jump and Branch_Taken sampled in a non-update cycle have no effect.
- Latency: PC change is visible the cycle after the qualifying edge; Imem_Req for the new PC is asserted in that same cycle.

Optional Feature:
Macro PC_MISALIGN_CHECK_EN.
- Defined:
  - Extra output port Misalign_Err (1 bit, reset 0).
  - When a PC update would load next_pc with next_pc[1:0]!=0, Misalign_Err sets and stays set until reset.
  - The loaded PC has bits [1:0] forced to 00.
- Not defined:
  - Port absent.
  - next_pc loaded unmodified.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding (BOOT, FETCH, HOLD)
  - PC_INCR=4
  - JUMP_FIELD_W=28
- One sub-module, pc_next_mux: purely combinational next-PC selection and the PC+4 adder.
- pc_sequencer keeps the FSM and registers.

Test Plan:
1. Reset release, Imem_Ack tied 1, Stall=0 -> Imem_Req=0 for one cycle, then PC=0,4,8,12 on consecutive cycles with Fetch_Valid pulsing each cycle.
2. PC=0x100, Branch_Taken=1, Branch_Offset=0xFFFF_FFF0 with ack -> PC=0x0F4; Branch_Offset=0x40 from PC=0x100 -> PC=0x144.
3. PC=0x4000_0010, Jump=1 and Branch_Taken=1, Jump_Field=0x000_0800 -> PC=0x4000_0800 (jump wins).
4. Ack with Stall=1 held 3 cycles -> PC frozen, Imem_Req=0 in HOLD, single Fetch_Valid pulse; Stall drops -> PC advances by 4 and Imem_Req reasserts.
5. Imem_Ack low for 5 cycles in FETCH -> PC and Imem_Req held, no Fetch_Valid; RST pulled low mid-wait -> PC=RESET_VECTOR, Imem_Req=0 immediately (asynchronously).
6. With PC_MISALIGN_CHECK_EN, branch from PC=0x20 with Branch_Offset=0x2 -> PC=0x24, Misalign_Err=1 and sticky; PC=0xFFFF_FFFC sequential -> PC=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: PC sequencer state encoding and fetch constants.
package mips_pkg;

    localparam int PC_INCR      = 4;
    localparam int JUMP_FIELD_W = 28;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection (jump > branch > sequential) and the PC+4 adder.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]        pc,
    input  logic                    jump,
    input  logic                    branch_taken,
    input  logic [WIDTH-1:0]        branch_offset,
    input  logic [JUMP_FIELD_W-1:0] jump_field,
    output logic [WIDTH-1:0]        pc_plus4,
    output logic [WIDTH-1:0]        next_pc
);

    logic [WIDTH-1:0] jump_target;

    assign pc_plus4 = pc + WIDTH'(PC_INCR);

    // The jump region comes from the delay-slot address, not the current PC.
    generate
        if (WIDTH > JUMP_FIELD_W) begin : g_region
            assign jump_target = {pc_plus4[WIDTH-1:JUMP_FIELD_W], jump_field};
        end else begin : g_no_region
            assign jump_target = jump_field[WIDTH-1:0];
        end
    endgenerate

    // NOTE: default assignment first so every path drives next_pc; no latch is inferred.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS program-counter stage: PC register plus BOOT/FETCH/HOLD fetch sequencer.
// Optional macro PC_MISALIGN_CHECK_EN adds a sticky Misalign_Err output.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Stall,
    input  logic                    Branch_Taken,
    input  logic                    Jump,
    input  logic [WIDTH-1:0]        Branch_Offset,
    input  logic [JUMP_FIELD_W-1:0] Jump_Field,
    input  logic                    Imem_Ack,
    output logic                    Imem_Req,
    output logic [WIDTH-1:0]        PC,
    output logic [WIDTH-1:0]        PC_Plus4,
`ifdef PC_MISALIGN_CHECK_EN
    output logic                    Misalign_Err,
`endif
    output logic                    Fetch_Valid
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             pc_load;
    logic             fetch_valid_nxt;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc_d;

    pc_next_mux #(
        .WIDTH (WIDTH)
    ) u_next_mux (
        .pc            (PC),
        .jump          (Jump),
        .branch_taken  (Branch_Taken),
        .branch_offset (Branch_Offset),
        .jump_field    (Jump_Field),
        .pc_plus4      (PC_Plus4),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_nxt       = state;
        pc_load         = 1'b0;
        fetch_valid_nxt = 1'b0;
        case (state)
            ST_BOOT: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (Imem_Ack) begin
                    fetch_valid_nxt = 1'b1;
                    if (Stall) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!Stall) begin
                    pc_load   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Derived from state so reset drops the request asynchronously.
    assign Imem_Req = (state == ST_FETCH);

`ifdef PC_MISALIGN_CHECK_EN
    assign pc_d = {next_pc[WIDTH-1:2], 2'b00};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Misalign_Err <= 1'b0;
        end else if (pc_load && word_misaligned(next_pc[1:0])) begin
            Misalign_Err <= 1'b1;
        end
    end
`else
    assign pc_d = next_pc;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_BOOT;
            PC          <= RESET_VECTOR;
            Fetch_Valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            Fetch_Valid <= fetch_valid_nxt;
            if (pc_load) begin
                PC <= pc_d;
            end
        end
    end

endmodule
